// File: rtl/clk_tick_gen_if.sv
// Divisor-programming and tick/status bundle of clk_tick_gen.
// The master side is the system integrator that writes divisors and consumes the strobes.
interface clk_tick_gen_if #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned DIV_W  = 16,
  parameter int unsigned CH_W   = 1
);
  logic                wr;
  logic [CH_W-1:0]     wr_ch;
  logic [DIV_W-1:0]    wr_div;
  logic                clk_ok;
  logic                rst_out;
  logic [NUM_CH-1:0]   tick;

  modport master (output wr, wr_ch, wr_div, input clk_ok, rst_out, tick);
  modport slave  (input wr, wr_ch, wr_div, output clk_ok, rst_out, tick);
endinterface

// File: rtl/clk_tick_gen.sv
// Lock-qualified clock-enable generator: waits for a stable PLL lock, then releases
// the system reset and emits phase-aligned per-channel tick strobes.
module clk_tick_gen #(
  parameter int unsigned               NUM_CH     = 2,
  parameter int unsigned               DIV_W      = 16,
  parameter logic [NUM_CH*DIV_W-1:0]   DIVS       = {16'd40, 16'd20},
  parameter int unsigned               STABLE_CYC = 1024,
  parameter int unsigned               CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          locked_in,
  clk_tick_gen_if.slave bus
);

  localparam int unsigned SC_W = (STABLE_CYC > 2) ? $clog2(STABLE_CYC) : 1;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILISE = 2'd1,
    RUN       = 2'd2
  } state_e;

  state_e            state_q;
  logic [SC_W-1:0]   stab_q;
  logic              sync1_q;
  logic              sync2_q;
  logic              clk_ok_q;
  logic              locked_s;

  logic [DIV_W-1:0]  cnt_q [NUM_CH];
  logic [DIV_W-1:0]  cnt_d [NUM_CH];
  logic [DIV_W-1:0]  div_q [NUM_CH];
  logic [DIV_W-1:0]  div_d [NUM_CH];
  logic [DIV_W-1:0]  shd_q [NUM_CH];
  logic [DIV_W-1:0]  shd_d [NUM_CH];
  logic [NUM_CH-1:0] wrap_c;

  // Two-flop synchroniser for the asynchronous lock indication
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= locked_in;
      sync2_q <= sync1_q;
    end
  end

  assign locked_s = sync2_q;

  // Lock qualification FSM; clk_ok_q tracks (state_q == RUN)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= WAIT_LOCK;
      stab_q   <= '0;
      clk_ok_q <= 1'b0;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          stab_q <= '0;
          if (locked_s) state_q <= STABILISE;
        end
        STABILISE: begin
          if (!locked_s) begin
            state_q <= WAIT_LOCK;
            stab_q  <= '0;
          end else if (stab_q + SC_W'(1) == SC_W'(STABLE_CYC - 1)) begin
            state_q  <= RUN;
            stab_q   <= '0;
            clk_ok_q <= 1'b1;
          end else begin
            stab_q <= stab_q + SC_W'(1);
          end
        end
        RUN: begin
          if (!locked_s) begin
            state_q  <= WAIT_LOCK;
            clk_ok_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= WAIT_LOCK;
          stab_q   <= '0;
          clk_ok_q <= 1'b0;
        end
      endcase
    end
  end

  // Per-channel counters; the shadow divisor lands in the active one at each wrap,
  // and a write in the wrap cycle itself goes straight through
  always_comb begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      wrap_c[c] = (div_q[c] <= DIV_W'(1)) || (cnt_q[c] == div_q[c] - DIV_W'(1));
      cnt_d[c]  = (clk_ok_q && locked_s && !wrap_c[c]) ? cnt_q[c] + DIV_W'(1) : '0;
      shd_d[c]  = (bus.wr && (32'(bus.wr_ch) == c)) ? bus.wr_div : shd_q[c];
      div_d[c]  = div_q[c];
      if (!clk_ok_q || wrap_c[c]) div_d[c] = shd_d[c];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        cnt_q[c] <= '0;
        div_q[c] <= DIVS[c*DIV_W +: DIV_W];
        shd_q[c] <= DIVS[c*DIV_W +: DIV_W];
      end
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        cnt_q[c] <= cnt_d[c];
        div_q[c] <= div_d[c];
        shd_q[c] <= shd_d[c];
      end
    end
  end

  assign bus.clk_ok  = clk_ok_q;
  assign bus.rst_out = ~clk_ok_q;
  assign bus.tick    = {NUM_CH{clk_ok_q}} & wrap_c;

endmodule

// File: tb/tb_clk_tick_gen.sv
// Randomised and directed bench for clk_tick_gen, checked every cycle against
// an event-time model of lock qualification and tick scheduling.
module tb_clk_tick_gen;
  localparam int unsigned NUM_CH     = 2;
  localparam int unsigned DIV_W      = 16;
  localparam int unsigned CH_W       = 2;
  localparam int unsigned STABLE_CYC = 16;
  localparam logic [NUM_CH*DIV_W-1:0] DIVS = {16'd40, 16'd20};

  logic clk = 1'b0;
  logic rst;
  logic locked_in;

  always #5 clk = ~clk;

  clk_tick_gen_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .CH_W(CH_W)) bus ();

  clk_tick_gen #(
    .NUM_CH(NUM_CH), .DIV_W(DIV_W), .DIVS(DIVS), .STABLE_CYC(STABLE_CYC), .CH_W(CH_W)
  ) dut (
    .clk(clk), .rst(rst), .locked_in(locked_in), .bus(bus)
  );

  int nvec = 0;
  int nerr = 0;

  // Reference model state: sync pipeline, lock run length, and per-channel tick schedule
  bit   q1, q2, run;
  int   ones, rn, cyc, run_start, rise_cyc;
  int   act [NUM_CH];
  int   shd [NUM_CH];
  int   nt  [NUM_CH];
  logic [NUM_CH-1:0] exp_tick;
  logic [2:0] hist [128];

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, a, e);
    end
  endtask

  function automatic int max1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  task automatic clear_hist();
    for (int i = 0; i < 128; i++) hist[i] = 'x;
  endtask

  task automatic model_reset();
    q1 = 0; q2 = 0; run = 0; ones = 0; rn = 0; cyc = 0;
    run_start = 1 << 30; rise_cyc = -1; exp_tick = '0;
    act[0] = 20; act[1] = 40;
    for (int c = 0; c < NUM_CH; c++) begin
      shd[c] = act[c];
      nt[c]  = 0;
    end
    clear_hist();
  endtask

  // Advance the model across one rising edge using the inputs present in cycle cyc
  task automatic model_step();
    int ones_n;
    bit run_n, tk, hit;
    ones_n = q2 ? ((ones < STABLE_CYC) ? ones + 1 : ones) : 0;
    run_n  = (ones_n >= STABLE_CYC);
    for (int c = 0; c < NUM_CH; c++) begin
      tk  = run && (rn == nt[c]);
      hit = bus.wr && (int'(bus.wr_ch) == c);
      if (hit) shd[c] = int'(bus.wr_div);
      if (!run || tk) act[c] = shd[c];
      if (run_n) begin
        if (!run) nt[c] = max1(act[c]) - 1;
        else if (tk) nt[c] = rn + max1(act[c]);
      end
    end
    if (run_n) begin
      if (!run) begin
        rn = 0;
        run_start = cyc + 1;
      end else begin
        rn++;
      end
    end
    run  = run_n;
    ones = ones_n;
    q2   = q1;
    q1   = locked_in;
    for (int c = 0; c < NUM_CH; c++) exp_tick[c] = run && (rn == nt[c]);
    cyc++;
  endtask

  task automatic compare();
    int off;
    chk("clk_ok", 32'(bus.clk_ok), 32'(run));
    chk("rst_out", 32'(bus.rst_out), 32'(!run));
    chk("tick", 32'(bus.tick), 32'(exp_tick));
    off = cyc - run_start;
    if (off >= 0 && off < 128) hist[off] = {bus.clk_ok, bus.tick};
    if (bus.clk_ok === 1'b1 && rise_cyc < 0) rise_cyc = cyc;
  endtask

  // Called at a falling edge; returns at the following falling edge
  task automatic cycle(input bit lk, input bit w, input int ch, input int dv);
    locked_in  = lk;
    bus.wr     = w;
    bus.wr_ch  = CH_W'(ch);
    bus.wr_div = DIV_W'(dv);
    @(posedge clk);
    model_step();
    #1;
    compare();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.wr = 1'b0;
    locked_in = 1'b0;
    #1;
    model_reset();
    chk("rst_clk_ok", 32'(bus.clk_ok), 32'd0);
    chk("rst_rst_out", 32'(bus.rst_out), 32'd1);
    chk("rst_tick", 32'(bus.tick), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic hchk(input string name, input int off, input logic [2:0] e);
    chk(name, 32'(hist[off]), 32'(e));
  endtask

  initial begin
    int drop;
    bit lk;
    rst = 1'b1; locked_in = 1'b0;
    bus.wr = 1'b0; bus.wr_ch = '0; bus.wr_div = '0;
    @(negedge clk);

    // Startup with default divisors, lock raised in cycle 10
    do_reset();
    for (int k = 0; k < 10; k++) cycle(0, 0, 0, 0);
    for (int k = 0; k < 60 && !run; k++) cycle(1, 0, 0, 0);
    chk("startup_rise", 32'(rise_cyc), 32'd28);
    for (int k = 0; k < 90; k++) cycle(1, 0, 0, 0);
    hchk("def_0", 0, 3'b100);   hchk("def_18", 18, 3'b100);
    hchk("def_19", 19, 3'b101); hchk("def_39", 39, 3'b111);
    hchk("def_59", 59, 3'b101); hchk("def_79", 79, 3'b111);

    // One-cycle lock glitch during stabilisation, then mid-period writes
    do_reset();
    for (int k = 0; k < 60 && !run; k++) cycle(k != 8, 0, 0, 0);
    chk("glitch_rise", 32'(rise_cyc), 32'd27);
    for (int k = 0; k < 90; k++)
      cycle(1, k == 25 || k == 27 || k == 28, (k == 25) ? 0 : ((k == 27) ? 3 : 2), (k == 25) ? 5 : 2);
    hchk("wr5_39", 39, 3'b111); hchk("wr5_41", 41, 3'b100);
    hchk("wr5_44", 44, 3'b101); hchk("wr5_49", 49, 3'b101);
    hchk("wr5_79", 79, 3'b111);

    // Async reset mid-RUN restores DIVS; write on wrap, div 0/1, then lock loss
    do_reset();
    for (int k = 0; k < 60 && !run; k++) cycle(1, 0, 0, 0);
    for (int k = 0; k < 70; k++)
      cycle(!(k >= 60 && k < 66), k == 19 || k == 25 || k == 26, (k == 26) ? 1 : 0,
            (k == 19) ? 3 : ((k == 25) ? 0 : 1));
    hchk("rstdiv_4", 4, 3'b100);  hchk("wrap_19", 19, 3'b101);
    hchk("wrap_20", 20, 3'b100);  hchk("wrap_22", 22, 3'b101);
    hchk("wrap_25", 25, 3'b101);  hchk("div0_26", 26, 3'b101);
    hchk("div0_38", 38, 3'b101);  hchk("div1_39", 39, 3'b111);
    hchk("div1_45", 45, 3'b111);  hchk("loss_62", 62, 3'b111);
    hchk("loss_63", 63, 3'b000);

    // Relock keeps the programmed divisors
    clear_hist();
    for (int k = 0; k < 60 && !run; k++) cycle(1, 0, 0, 0);
    for (int k = 0; k < 10; k++) cycle(1, 0, 0, 0);
    hchk("relock_0", 0, 3'b111); hchk("relock_5", 5, 3'b111);

    // Random writes, lock drops and occasional resets
    drop = 0;
    for (int k = 0; k < 4000; k++) begin
      if (drop > 0) drop--;
      else if ($urandom_range(0, 299) == 0) drop = $urandom_range(1, 5);
      lk = (drop == 0);
      if ($urandom_range(0, 1999) == 0) do_reset();
      cycle(lk, $urandom_range(0, 4) == 0, $urandom_range(0, 3),
            ($urandom_range(0, 7) == 0) ? $urandom_range(0, 200) : $urandom_range(0, 9));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/clk_tick_gen.md
# clk_tick_gen

Lock-qualified clock-enable generator for the system clock domain. Sits directly behind the PLL clock generator: it waits for the PLL lock indication to remain stable, then releases a synchronous system reset and produces NUM_CH phase-aligned, single-cycle tick strobes with individually parametrised and run-time reprogrammable divisors. It replaces ad-hoc divided clocks with clock enables on the single system clock.

## Interface
Parameters:
- NUM_CH, 2: number of tick channels (1..16).
- DIV_W, 16: divisor width in bits.
- DIVS, {16'd40, 16'd20}: reset divisors, NUM_CH×DIV_W packed; channel 0 in the LSBs.
- STABLE_CYC, 1024: consecutive cycles of synchronised lock required before run (≥2).
- CH_W, $clog2(NUM_CH) (minimum 1): channel select width.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- locked_in  in  1  PLL lock; asynchronous to clk, 2-FF synchronised internally to locked_s.
- wr  in  1  divisor write strobe, one cycle.
- wr_ch  in  CH_W  target channel for wr.
- wr_div  in  DIV_W  new divisor for wr_ch.
- clk_ok  out  1  high in RUN state.
- rst_out  out  1  synchronous active-high reset for downstream logic; always ~clk_ok.
- tick  out  NUM_CH  per-channel clock-enable strobes.

## Operation
- Reset values: state WAIT_LOCK, stable counter 0, sync FFs 0, clk_ok 0, rst_out 1, tick all 0, channel counters 0, active and shadow divisors = DIVS.
- Control FSM, three states:
  - WAIT_LOCK: stable counter held at 0. Goes to STABILISE when locked_s = 1.
  - STABILISE: stable counter increments each cycle. Returns to WAIT_LOCK if locked_s = 0. Goes to RUN when the counter reaches STABLE_CYC−1 with locked_s = 1.
  - RUN: clk_ok = 1. Returns to WAIT_LOCK if locked_s = 0.
- clk_ok and rst_out are decoded from the registered state (no extra latency).
- Channel counters (DIV_W bits):
  - Outside RUN: held at 0, tick 0.
  - In RUN: count 0..div−1, then wrap to 0.
  - tick[c] = 1 in exactly the cycles where counter[c] == div[c]−1.
  - div 0 and div 1 both mean tick[c] high every RUN cycle.
  - All counters start together on the first RUN cycle, so channels with commensurate divisors stay phase-aligned.
- Divisor write:
  - On wr with wr_ch < NUM_CH, shadow[wr_ch] ← wr_div. wr_ch ≥ NUM_CH is ignored.
  - Shadow is copied to active at the channel's next wrap (the tick cycle), so no period is truncated.
  - Outside RUN, the copy happens on the next cycle.
  - wr in the same cycle as the target channel's wrap: the new wr_div becomes active for the immediately following period (write bypasses shadow).
- Loss of lock mid-operation: the next cycle after locked_s falls, clk_ok = 0, rst_out = 1, ticks 0, counters 0. Active divisors are retained, not reset to DIVS.
- Async rst at any time returns everything to reset values, including programmed divisors.

## Timing
- locked_in to locked_s: 2 clk cycles.
- clk_ok rises STABLE_CYC cycles after the first cycle locked_s = 1, provided locked_s stays high throughout.
- First RUN cycle is cycle 0; channel c first ticks in cycle DIV_c−1, then every DIV_c cycles.
- tick width: exactly one cycle (except div ≤ 1).
- Write-to-effect latency: until the next wrap of that channel, at most the old period.
- clk_ok fall: 1 cycle after locked_s falls; 3 cycles after locked_in falls.

## Test plan
- Lock startup, STABLE_CYC=16: rst released, locked_in raised at cycle 10 -> clk_ok and rst_out unchanged until cycle 10+2+16; then clk_ok=1, rst_out=0.
- Lock glitch: locked_in low for 1 cycle during STABILISE -> counter restarts; clk_ok rise delayed by a full STABLE_CYC after the glitch.
- Default divisors 20/40 -> tick[0] in RUN cycles 19, 39, 59…; tick[1] in cycles 39, 79…; coincident at 39, 79.
- Write div 5 to ch0 at RUN cycle 25 -> tick at 39 (old period completes), then 44, 49…; write to wr_ch=3 with NUM_CH=2 -> no change.
- Write coincident with wrap: wr_div=3 to ch0 at cycle 19 -> ticks at 19, 22, 25…; div 1 and div 0 -> tick constantly high in RUN.
- Lock loss in RUN: locked_in low at cycle 30 -> clk_ok=0, rst_out=1, ticks 0 from cycle 33; relock reuses the programmed divisors; async rst mid-RUN -> immediate reset values, divisors back to DIVS.
